// File: rtl/note_envelope_sequencer_if.sv
// Audio_Controller output-FIFO handshake: write strobe plus the stereo sample pair.
// The master drives the samples; the slave reports FIFO space.
interface note_envelope_sequencer_if;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/note_envelope_sequencer.sv
// One piano voice: one-hot key -> square tone, ADSR volume envelope, scaled stereo
// samples streamed into Audio_Controller's output FIFO.
module note_envelope_sequencer #(
  parameter logic [23:0] AMPLITUDE     = 24'd10000000,
  parameter int          ATTACK_STEP   = 8,
  parameter int          DECAY_DIV     = 64,
  parameter int          SUSTAIN_LEVEL = 128,
  parameter int          RELEASE_STEP  = 4
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic [9:0]                        note_sel,
  note_envelope_sequencer_if.master         aud,
  output logic                              voice_active,
  output logic [7:0]                        envelope
);

  localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ATTACK, DECAY, RELEASE} state_t;

  state_t          state, state_d;
  logic [7:0]      volume, volume_d;
  logic [DCW-1:0]  decay_cnt, decay_cnt_d;
  logic [9:0]      note, note_d;
  logic [16:0]     half_period, half_period_d;
  logic [16:0]     tone_cnt;
  logic            snd;
  logic            restart;
  logic            note_valid;
  logic            write_cycle;
  logic [8:0]      vol_up;
  logic [31:0]     product;
  logic [31:0]     mag;
  logic [31:0]     sample;

  // Half-period in CLOCK_50 cycles, C4 (bit0) through E5 (bit9).
  function automatic logic [16:0] half_period_of(input logic [9:0] sel);
    case (sel)
      10'b0000000001: half_period_of = 17'd95554;
      10'b0000000010: half_period_of = 17'd85132;
      10'b0000000100: half_period_of = 17'd75842;
      10'b0000001000: half_period_of = 17'd71586;
      10'b0000010000: half_period_of = 17'd63775;
      10'b0000100000: half_period_of = 17'd56818;
      10'b0001000000: half_period_of = 17'd50620;
      10'b0010000000: half_period_of = 17'd47778;
      10'b0100000000: half_period_of = 17'd42568;
      10'b1000000000: half_period_of = 17'd37922;
      default:        half_period_of = 17'd0;
    endcase
  endfunction

  assign note_valid          = $onehot(note_sel);
  assign write_cycle         = aud.audio_out_allowed & ~reset;
  assign aud.write_audio_out = write_cycle;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      volume      <= 8'd0;
      decay_cnt   <= '0;
      note        <= 10'd0;
      half_period <= 17'd0;
    end else begin
      state       <= state_d;
      volume      <= volume_d;
      decay_cnt   <= decay_cnt_d;
      note        <= note_d;
      half_period <= half_period_d;
    end
  end

  // Note changes pre-empt the envelope: a transition cycle never also steps volume.
  always_comb begin
    state_d       = state;
    volume_d      = volume;
    decay_cnt_d   = decay_cnt;
    note_d        = note;
    half_period_d = half_period;
    restart       = 1'b0;
    vol_up        = {1'b0, volume} + 9'(ATTACK_STEP);

    if (state == IDLE) begin
      if (note_valid) begin
        note_d        = note_sel;
        half_period_d = half_period_of(note_sel);
        restart       = 1'b1;
        state_d       = ATTACK;
      end
    end else if (note_valid && (note_sel != note)) begin
      note_d        = note_sel;
      half_period_d = half_period_of(note_sel);
      restart       = 1'b1;
      state_d       = ATTACK;
    end else if (!note_valid && (state != RELEASE)) begin
      state_d = RELEASE;
    end else if (write_cycle) begin
      case (state)
        ATTACK: begin
          if (vol_up >= 9'd255) begin
            volume_d    = 8'd255;
            decay_cnt_d = '0;
            state_d     = DECAY;
          end else begin
            volume_d = vol_up[7:0];
          end
        end
        DECAY: begin
          if (decay_cnt == DCW'(DECAY_DIV - 1)) begin
            decay_cnt_d = '0;
            if (volume > 8'(SUSTAIN_LEVEL))
              volume_d = volume - 8'd1;
          end else begin
            decay_cnt_d = decay_cnt + DCW'(1);
          end
        end
        RELEASE: begin
          if (volume <= 8'(RELEASE_STEP)) begin
            volume_d = 8'd0;
            state_d  = IDLE;
          end else begin
            volume_d = volume - 8'(RELEASE_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  // Tone keeps running under backpressure; only a (re)start or IDLE clears it.
  always_ff @(posedge CLOCK_50) begin
    if (reset || restart || (state == IDLE)) begin
      tone_cnt <= 17'd0;
      snd      <= 1'b0;
    end else if (tone_cnt == half_period) begin
      tone_cnt <= 17'd0;
      snd      <= ~snd;
    end else begin
      tone_cnt <= tone_cnt + 17'd1;
    end
  end

  assign product = 32'(AMPLITUDE) * {24'd0, volume};
  assign mag     = product >> 8;

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      sample <= 32'd0;
    else
      sample <= snd ? mag : (32'd0 - mag);
  end

  assign aud.left_channel_audio_out  = sample;
  assign aud.right_channel_audio_out = sample;
  assign voice_active                = (state != IDLE);
  assign envelope                    = volume;

endmodule

// File: tb/tb_note_envelope_sequencer.sv
// Bench for note_envelope_sequencer: per-cycle scoreboard against a behavioural voice
// model, plus a table of hand-derived checkpoints and a short retrigger-from-release sequence.
`timescale 1ns/1ps
module tb_note_envelope_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [9:0] note_sel;
  logic       voice_active;
  logic [7:0] envelope;

  note_envelope_sequencer_if aud();

  note_envelope_sequencer dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .note_sel     (note_sel),
    .aud          (aud),
    .voice_active (voice_active),
    .envelope     (envelope)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0]  env;
    logic        active;
    logic [31:0] sample;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [9:0] sel;
    logic       allowed;
    int         cycles;
    logic [7:0] env;
    logic       active;
    int         sample;
  } vec_t;

  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_RELEASE = 3;

  exp_t sb[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  int         m_state = S_IDLE, m_vol = 0, m_snd = 0, m_cnt = 0, m_half = 0, m_dcnt = 0;
  logic [9:0] m_note = 10'd0;
  int         half_tab [10] = '{95554, 85132, 75842, 71586, 63775, 56818, 50620, 47778, 42568, 37922};

  function automatic int half_of(input logic [9:0] sel);
    for (int i = 0; i < 10; i++)
      if (sel[i]) return half_tab[i];
    return 0;
  endfunction

  function automatic logic [31:0] model_sample(input int vol, input int s);
    longint m;
    m = (longint'(10000000) * longint'(vol)) / 256;
    return s != 0 ? 32'(m) : 32'(-m);
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (envelope !== e.env || voice_active !== e.active ||
        aud.left_channel_audio_out !== e.sample || aud.right_channel_audio_out !== e.sample) begin
      errors++;
      $display("[TB] FAIL cycle_out at %0t: got env=%0d active=%b L=%0d R=%0d, expected env=%0d active=%b L=R=%0d",
               $time, envelope, voice_active, $signed(aud.left_channel_audio_out),
               $signed(aud.right_channel_audio_out), e.env, e.active, $signed(e.sample));
    end
  endtask

  // One clock: drive, check the combinational strobe, advance the model, compare after the edge.
  task automatic applyStimulus(input logic r, input logic [9:0] sel, input logic al);
    exp_t e;
    logic exp_wr;
    bit   valid;
    reset = r;
    note_sel = sel;
    aud.audio_out_allowed = al;
    #1;
    exp_wr = al & ~r;
    checks++;
    if (aud.write_audio_out !== exp_wr) begin
      errors++;
      $display("[TB] FAIL write_strobe at %0t: got %b, expected %b", $time, aud.write_audio_out, exp_wr);
    end
    e.sample = r ? 32'd0 : model_sample(m_vol, m_snd);
    if (r) begin
      m_state = S_IDLE; m_vol = 0; m_snd = 0; m_cnt = 0; m_dcnt = 0; m_half = 0; m_note = 10'd0;
    end else begin
      valid = ($countones(sel) == 1);
      if (m_state == S_IDLE) begin
        m_cnt = 0; m_snd = 0;
      end else if (m_cnt == m_half) begin
        m_cnt = 0; m_snd = 1 - m_snd;
      end else begin
        m_cnt++;
      end
      if (m_state == S_IDLE) begin
        if (valid) begin
          m_note = sel; m_half = half_of(sel); m_cnt = 0; m_snd = 0; m_state = S_ATTACK;
        end
      end else if (valid && sel != m_note) begin
        m_note = sel; m_half = half_of(sel); m_cnt = 0; m_snd = 0; m_state = S_ATTACK;
      end else if (!valid && m_state != S_RELEASE) begin
        m_state = S_RELEASE;
      end else if (exp_wr) begin
        if (m_state == S_ATTACK) begin
          m_vol += 8;
          if (m_vol >= 255) begin m_vol = 255; m_dcnt = 0; m_state = S_DECAY; end
        end else if (m_state == S_DECAY) begin
          m_dcnt++;
          if (m_dcnt == 64) begin m_dcnt = 0; if (m_vol > 128) m_vol--; end
        end else begin
          m_vol -= 4;
          if (m_vol <= 0) begin m_vol = 0; m_state = S_IDLE; end
        end
      end
    end
    e.env = 8'(m_vol);
    e.active = (m_state != S_IDLE);
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    checkOutput();
  endtask

  task automatic checkNow(input string name, input logic [7:0] env, input logic act, input int smp);
    checks++;
    if (envelope !== env || voice_active !== act || aud.left_channel_audio_out !== 32'(smp)) begin
      errors++;
      $display("[TB] FAIL %s: got env=%0d active=%b sample=%0d, expected env=%0d active=%b sample=%0d",
               name, envelope, voice_active, $signed(aud.left_channel_audio_out), env, act, smp);
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset, then first post-reset cycle behaves as IDLE
    vecs.push_back('{1'b1, 10'd1,   1'b1, 3,     8'd0,   1'b0, 0});
    vecs.push_back('{1'b0, 10'd1,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 2,     8'd0,   1'b0, 0});
    // attack / decay / sustain on note bit5, including the first tone edge
    vecs.push_back('{1'b0, 10'd32,  1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 31,    8'd248, 1'b1, -9375000});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 1,     8'd255, 1'b1, -9687500});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 63,    8'd255, 1'b1, -9960937});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 1,     8'd254, 1'b1, -9960937});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 8064,  8'd128, 1'b1, -5039062});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 48659, 8'd128, 1'b1, -5000000});
    vecs.push_back('{1'b0, 10'd32,  1'b1, 1,     8'd128, 1'b1, 5000000});
    // release from sustain
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd128, 1'b1, 5000000});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 32,    8'd0,   1'b0, 156250});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd0,   1'b0, 0});
    // retrigger during decay at 200
    vecs.push_back('{1'b0, 10'd1,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd1,   1'b1, 32,    8'd255, 1'b1, -9687500});
    vecs.push_back('{1'b0, 10'd1,   1'b1, 3520,  8'd200, 1'b1, -7851562});
    vecs.push_back('{1'b0, 10'd512, 1'b1, 1,     8'd200, 1'b1, -7812500});
    vecs.push_back('{1'b0, 10'd512, 1'b1, 6,     8'd248, 1'b1, -9375000});
    vecs.push_back('{1'b0, 10'd512, 1'b1, 1,     8'd255, 1'b1, -9687500});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd255, 1'b1, -9960937});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 64,    8'd0,   1'b0, -117187});
    // backpressure mid-attack
    vecs.push_back('{1'b0, 10'd4,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd4,   1'b1, 10,    8'd80,  1'b1, -2812500});
    vecs.push_back('{1'b0, 10'd4,   1'b0, 1000,  8'd80,  1'b1, -3125000});
    vecs.push_back('{1'b0, 10'd4,   1'b1, 2,     8'd96,  1'b1, -3437500});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd96,  1'b1, -3750000});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 24,    8'd0,   1'b0, -156250});
    // multi-hot select: ignored in IDLE, releases an active voice
    vecs.push_back('{1'b0, 10'd3,   1'b1, 5,     8'd0,   1'b0, 0});
    vecs.push_back('{1'b0, 10'd8,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd8,   1'b1, 3,     8'd24,  1'b1, -625000});
    vecs.push_back('{1'b0, 10'd3,   1'b1, 1,     8'd24,  1'b1, -937500});
    vecs.push_back('{1'b0, 10'd3,   1'b1, 6,     8'd0,   1'b0, -156250});
    // reset mid-note aborts at once
    vecs.push_back('{1'b0, 10'd8,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd8,   1'b1, 4,     8'd32,  1'b1, -937500});
    vecs.push_back('{1'b1, 10'd8,   1'b1, 1,     8'd0,   1'b0, 0});
    vecs.push_back('{1'b0, 10'd8,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd0,   1'b1, 0});
    vecs.push_back('{1'b0, 10'd0,   1'b1, 1,     8'd0,   1'b0, 0});

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        applyStimulus(vecs[i].rst, vecs[i].sel, vecs[i].allowed);
      checkNow($sformatf("vec[%0d]", i), vecs[i].env, vecs[i].active, vecs[i].sample);
    end

    // new note arriving during RELEASE restarts ATTACK from the current volume
    applyStimulus(1'b0, 10'd16, 1'b1);
    applyStimulus(1'b0, 10'd16, 1'b1);
    applyStimulus(1'b0, 10'd16, 1'b1);
    applyStimulus(1'b0, 10'd0, 1'b1);
    applyStimulus(1'b0, 10'd0, 1'b1);
    checkNow("release_step", 8'd12, 1'b1, -625000);
    applyStimulus(1'b0, 10'd64, 1'b1);
    checkNow("retrigger_from_release", 8'd12, 1'b1, -468750);
    applyStimulus(1'b0, 10'd64, 1'b1);
    checkNow("attack_after_retrigger", 8'd20, 1'b1, -468750);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_envelope_sequencer.md
Name: note_envelope_sequencer

Overview:
- Controller that sequences the audio output datapath for one piano voice.
- Decodes a one-hot key selection into a square-wave tone.
- Applies an attack/decay/sustain/release volume envelope.
- Feeds scaled stereo samples into Audio_Controller's output FIFO through its audio_out_allowed/write_audio_out handshake. Sits between the switch/key inputs and Audio_Controller in the top level.

Parameters:
- AMPLITUDE, 24'd10000000, full-scale square magnitude before envelope scaling.
- ATTACK_STEP, 8, volume increment per written sample in ATTACK.
- DECAY_DIV, 64, written samples per 1-step volume decrement in DECAY.
- SUSTAIN_LEVEL, 128, volume floor for DECAY (1..255).
- RELEASE_STEP, 4, volume decrement per written sample in RELEASE.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- note_sel  in  10  one-hot key select; bit0=C4 .. bit9=E5.
- audio_out_allowed  in  1  Audio_Controller output FIFO has space.
- write_audio_out  out  1  write strobe to Audio_Controller.
- left_channel_audio_out  out  32  signed sample, left.
- right_channel_audio_out  out  32  signed sample, right (identical to left).
- voice_active  out  1  high when state != IDLE.
- envelope  out  8  current volume.

Behaviour:
- One clock (CLOCK_50); reset is synchronous and active-high. All state updates on the rising edge.
- Reset values: state=IDLE, volume=0, snd=0, tone counter=0, decay counter=0, latched note=0, sample outputs=0, voice_active=0, envelope=0, write_audio_out=0. Reset mid-note aborts immediately; the first cycle after reset deasserts behaves as IDLE.
- Valid note: note_sel has exactly one bit set. Zero or multi-hot counts as "no note".
- Half-period table (CLOCK_50 cycles), bit0..bit9: 95554, 85132, 75842, 71586, 63775, 56818, 50620, 47778, 42568, 37922.
- Tone generator:
  - While state != IDLE, the counter increments each cycle.
  - When counter == half_period: counter<=0 and snd toggles. Full period = 2*(half_period+1) cycles.
  - In IDLE: counter is held at 0 and snd at 0.
- Handshake:
  - write_audio_out = audio_out_allowed & ~reset (combinational).
  - Sample outputs are registered and always valid. A write cycle is any cycle with write_audio_out=1.
  - Envelope advances only on write cycles.
  - In IDLE, writes continue with sample 0 so the codec stream never starves.
- Sample arithmetic:
  - mag = (AMPLITUDE * volume) >> 8, 32-bit unsigned product.
  - sample = snd ? mag : -mag (32-bit two's complement). Registered every cycle, so a volume or snd change appears on the outputs one cycle later.
  - Both channels are equal. volume=0 gives exactly 0.
- State machine:
  - IDLE:
    - Valid note -> latch note, load half_period, counter=0, snd=0 -> ATTACK.
  - ATTACK:
    - On each write, volume = min(volume+ATTACK_STEP, 255).
    - On reaching 255 -> DECAY, with decay counter=0.
  - DECAY:
    - On each write, the decay counter increments.
    - When it hits DECAY_DIV-1: counter=0 and volume decrements, but not below SUSTAIN_LEVEL. At SUSTAIN_LEVEL, volume holds.
  - RELEASE:
    - On each write, volume = max(volume-RELEASE_STEP, 0).
    - On reaching 0 -> IDLE.
  - Any non-IDLE state:
    - no note -> RELEASE.
    - A valid note different from the latched note is a retrigger: latch the new note, counter=0, snd=0 -> ATTACK, with volume continuing from its current value. This includes a new valid note arriving during RELEASE.
- Priority within one cycle: reset > retrigger/new note > no-note release > envelope step.
- A note change and a write in the same cycle: the transition takes effect and no envelope step is applied that cycle.
- voice_active = (state != IDLE). envelope = volume.

Test Plan:
- Reset: assert reset 3 cycles with note_sel=10'd1 and audio_out_allowed=1 -> write_audio_out=0, samples=0, envelope=0, voice_active=0. After release, ATTACK is entered on the next cycle.
- Attack/decay: note_sel=10'd32, audio_out_allowed=1 constant -> envelope reaches 255 after 32 writes, then DECAY. After a further 127*64=8128 writes, envelope=128 and holds. snd toggles every 56819 cycles.
- Release: from sustain (128), set note_sel=0 -> envelope falls by 4 per write, reaching 0 after 32 writes. State returns to IDLE, voice_active=0, samples=0.
- Retrigger: during DECAY at volume 200, switch note_sel from 10'd1 to 10'd512 -> ATTACK from 200, reaching 255 after 7 writes. Tone counter restarts, and the half-period becomes 37922.
- Backpressure: hold audio_out_allowed=0 for 1000 cycles mid-ATTACK -> write_audio_out=0, envelope frozen, tone counter keeps running. Envelope resumes when allowed returns.
- Invalid select: note_sel=10'b0000000011 from IDLE -> remains IDLE. Same value during ATTACK -> RELEASE.
